iir_decimator: RTL and testbench
================================

// Module: iir_decimator
// PURPOSE
//  Downstream stage of iir_filter. Consumes the filtered sample stream y, averages
//  each block of 2**DECIM_LOG2 samples (boxcar average plus decimation), and
//  buffers the results in a small FIFO. Results leave on a valid/ready interface.
//  Drops results and flags overflow when the consumer stalls too long.
// PARAMETERS
//  DATA_W      16  signed sample width (in and out)
//  DECIM_LOG2  2   log2 of decimation factor N (N=4); legal range 1..8
//  FIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1                    system clock, rising edge
//  reset_n     in   1                    asynchronous reset, active-low
//  sync_clr    in   1                    synchronous clear of datapath, FIFO and overflow
//  in_valid    in   1                    in_data carries a sample this cycle
//  in_data     in   DATA_W               signed sample (iir_filter y)
//  out_valid   out  1                    out_data holds head of FIFO
//  out_ready   in   1                    consumer accepts out_data this cycle
//  out_data    out  DATA_W               signed averaged sample
//  fifo_level  out  $clog2(FIFO_DEPTH)+1 number of stored results
//  overflow    out  1                    sticky: a result was dropped
// BEHAVIOUR
//  - Reset (reset_n=0, async): acc=0, cnt=0, FIFO empty; out_valid=0, out_data=0,
//    fifo_level=0, overflow=0. Applies immediately; any partial block is discarded.
//  - sync_clr=1: same effect as reset at the next edge. Overrides in_valid/out_ready.
//  - Accumulator: signed, DATA_W+DECIM_LOG2 bits, no overflow possible.
//    cnt is 0..N-1. Cycles with in_valid=0 do not change acc or cnt.
//  - FSM: ACCUM (cnt<N-1) -> DUMP when cnt==N-1 and in_valid=1.
//    DUMP is the same edge: push sum=acc+in_data, acc<=0, cnt<=0.
//  - Result = sum >>> DECIM_LOG2 (arithmetic shift); exactly fits DATA_W.
//  - Latency: out_valid rises the cycle after the edge that samples the Nth input.
//    There is no same-cycle fall-through.
//  - FIFO is show-ahead: out_data = head whenever out_valid=1. out_data holds its
//    value while out_valid=1 and out_ready=0. out_data=0 when empty.
//  - Pop on out_valid & out_ready. Push on DUMP.
//    Full with push and no pop: result dropped, overflow<=1 (cleared only by
//    reset/sync_clr). Full with push and pop in the same cycle: both occur, level unchanged.
//    Empty: out_ready ignored.
//  - fifo_level is registered and exact; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  DECIM_ROUND_EN defined: result = (sum + 2**(DECIM_LOG2-1)) >>> DECIM_LOG2
//    (round half toward +inf). The addition is done at DATA_W+DECIM_LOG2+1 bits and
//    the result is clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//  Undefined: plain arithmetic shift (truncate toward -inf), no clamp logic.
// TESTING (defaults N=4, DEPTH=4)
//  1 in 100,150,200,250 back-to-back, out_ready=1
//    -> out_valid=1 for one cycle, out_data=175, one cycle after 4th sample edge.
//  2 in -1,-1,-1,-2 (sum -5) -> out_data=-2; with DECIM_ROUND_EN -> -1.
//    Also 4x32767 -> 32767 and 4x-32768 -> -32768, both builds.
//  3 out_ready=0, 20 valid samples of value k*4 (k=1..20)
//    -> fifo_level=4, overflow=1 after 5th result.
//    Then out_ready=1 drains 10,26,42,58 in order; the 5th result is never seen.
//  4 FIFO full, out_ready=1 on the cycle a result is pushed
//    -> level stays 4, overflow stays 0, order preserved.
//  5 in_valid toggling 1/0 with samples 8,X,8,X,8,X,8 (X ignored) -> out_data=8.
//  6 reset_n=0 after 2 samples of a block -> outputs 0 immediately.
//    Next 4 samples 40,40,40,40 -> out_data=40.
//    Repeat with sync_clr instead of reset_n; same result, and overflow clears.

Source files
------------

// File: rtl/iir_decimator.sv
// iir_decimator: boxcar average + decimate-by-2**DECIM_LOG2 of a signed
// sample stream, results buffered in a show-ahead FIFO on valid/ready.
// Optional macro DECIM_ROUND_EN: round half toward +inf and clamp.
// Ports:
//   clk, reset_n (async, active-low), sync_clr (sync clear of everything)
//   in_valid/in_data   : signed input samples
//   out_valid/out_ready/out_data : averaged results (head of FIFO)
//   fifo_level         : stored result count
//   overflow           : sticky, a result was dropped on a full FIFO
module iir_decimator #(
    parameter int DATA_W     = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sync_clr,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int SW = DATA_W + DECIM_LOG2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic signed [SW-1:0]     r_acc;
    logic [DECIM_LOG2-1:0]    r_cnt;
    logic [DATA_W-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wptr;
    logic [AW-1:0]            r_rptr;
    logic [AW:0]              r_level;
    logic                     r_ovf;

    logic signed [SW-1:0]     w_sum;
    logic                     w_dump;
    logic [DATA_W-1:0]        w_res;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_wr;
    logic                     w_unused_lsb;

    assign w_sum  = r_acc + {{DECIM_LOG2{in_data[DATA_W-1]}}, in_data};
    // Block ends on the sample taken while cnt sits at N-1.
    assign w_dump = in_valid & (&r_cnt);

`ifdef DECIM_ROUND_EN
    localparam logic [SW:0] HALF = (SW+1)'(1) << (DECIM_LOG2 - 1);

    logic [SW:0]     w_rnd;
    logic [DATA_W:0] w_q;

    // One guard bit so the +half cannot wrap before the shift.
    assign w_rnd = {w_sum[SW-1], w_sum} + HALF;
    assign w_q   = w_rnd[SW:DECIM_LOG2];

    always_comb begin
        w_res = w_q[DATA_W-1:0];
        if (w_q[DATA_W] != w_q[DATA_W-1]) begin
            w_res = w_q[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign w_unused_lsb = ^w_rnd[DECIM_LOG2-1:0];
`else
    // Dropping the low bits is the arithmetic shift.
    assign w_res        = w_sum[SW-1:DECIM_LOG2];
    assign w_unused_lsb = ^w_sum[DECIM_LOG2-1:0];
`endif

    assign w_pop  = out_valid & out_ready;
    assign w_full = (r_level == FULL);
    assign w_wr   = w_dump & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (in_valid) begin
            if (w_dump) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (sync_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_res;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_wr && w_pop) r_level <= r_level - 1'b1;
            if (w_dump && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = out_valid ? r_mem[r_rptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_iir_decimator.sv
// tb_iir_decimator: directed scenarios plus a randomized run checked
// against a queue-based behavioural model of the decimator.
module tb_iir_decimator;

    localparam int DW = 16;
    localparam int L  = 2;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sync_clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_data;
    logic [LW-1:0]        fifo_level;
    logic                 overflow;

    int n_chk = 0;
    int n_err = 0;

    iir_decimator #(.DATA_W(DW), .DECIM_LOG2(L), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_clr   (sync_clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_q[$];
    int m_sum;
    int m_cnt;
    bit m_ovf;
    bit m_pop;
    int m_res;

    function automatic int avg(input int sum);
        int s;
        int r;
        s = sum;
`ifdef DECIM_ROUND_EN
        s = s + N / 2;
`endif
        r = s / N;
        if (s < 0 && (s % N) != 0) r = r - 1;
`ifdef DECIM_ROUND_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || sync_clr) begin
            m_q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 0;
        end else begin
            m_pop = out_ready && (m_q.size() > 0);
            if (m_pop) void'(m_q.pop_front());
            if (in_valid) begin
                m_sum = m_sum + int'(in_data);
                m_cnt = m_cnt + 1;
                if (m_cnt == N) begin
                    m_res = avg(m_sum);
                    if (m_q.size() < D) m_q.push_back(m_res);
                    else m_ovf = 1;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic signed [DW-1:0] d,
                        input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 ||
            fifo_level !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: v=%b d=%0d lvl=%0d ovf=%b want 0/0/0/0",
                     out_valid, out_data, fifo_level, overflow);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 0, 0);
    endtask

    task automatic test_average;
        step(1, 100, 1);
        step(1, 150, 1);
        step(1, 200, 1);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL avg_early: out_valid=%b want 0", out_valid);
        end
        step(1, 250, 1);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 16'sd175) begin
            n_err++;
            $display("FAIL avg_175: v=%b d=%0d want 1/175",
                     out_valid, out_data);
        end
        step(0, 0, 1);
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL avg_pop: v=%b d=%0d want 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_extremes;
        logic signed [DW-1:0] pat [3][4];
        logic signed [DW-1:0] exp [3];
        pat[0] = '{-16'sd1, -16'sd1, -16'sd1, -16'sd2};
        pat[1] = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        pat[2] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
`ifdef DECIM_ROUND_EN
        exp[0] = -16'sd1;
`else
        exp[0] = -16'sd2;
`endif
        exp[1] = 16'sd32767;
        exp[2] = -16'sd32768;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 4; j++) step(1, pat[p][j], 0);
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== exp[p] ||
                fifo_level !== 3'd1) begin
                n_err++;
                $display("FAIL extreme%0d: v=%b d=%0d lvl=%0d want 1/%0d/1",
                         p, out_valid, out_data, fifo_level, exp[p]);
            end
            step(0, 0, 1);
        end
    endtask

    task automatic test_overflow;
        logic signed [DW-1:0] exp [4];
        exp = '{16'sd10, 16'sd26, 16'sd42, 16'sd58};
        for (int k = 1; k <= 20; k++) begin
            step(1, DW'(k * 4), 0);
            if (k == 16) begin
                n_chk++;
                if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_full: lvl=%0d ovf=%b want 4/0",
                             fifo_level, overflow);
                end
            end
        end
        n_chk++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: lvl=%0d ovf=%b want 4/1",
                     fifo_level, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_err++;
                $display("FAIL ovf_drain%0d: v=%b d=%0d want 1/%0d",
                         i, out_valid, out_data, exp[i]);
            end
            step(0, 0, 1);
        end
        n_chk++;
        if (out_valid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_empty: v=%b lvl=%0d ovf=%b want 0/0/1",
                     out_valid, fifo_level, overflow);
        end
        sync_clr = 1'b1;
        step(0, 0, 0);
        sync_clr = 1'b0;
    endtask

    task automatic test_full_pushpop;
        logic signed [DW-1:0] exp [4];
        exp = '{16'sd20, 16'sd30, 16'sd40, 16'sd50};
        for (int b = 1; b <= 4; b++)
            for (int j = 0; j < 4; j++) step(1, DW'(b * 10), 0);
        n_chk++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL pp_fill: lvl=%0d ovf=%b want 4/0",
                     fifo_level, overflow);
        end
        for (int j = 0; j < 3; j++) step(1, 16'sd50, 0);
        step(1, 16'sd50, 1);
        n_chk++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL pp_same: lvl=%0d ovf=%b want 4/0",
                     fifo_level, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_err++;
                $display("FAIL pp_order%0d: v=%b d=%0d want 1/%0d",
                         i, out_valid, out_data, exp[i]);
            end
            step(0, 0, 1);
        end
    endtask

    task automatic test_gaps;
        for (int j = 0; j < 7; j++) begin
            if (j % 2 == 0) step(1, 16'sd8, 0);
            else step(0, DW'($urandom), 0);
        end
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 16'sd8 ||
            fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL gaps: v=%b d=%0d lvl=%0d want 1/8/1",
                     out_valid, out_data, fifo_level);
        end
        step(0, 0, 1);
    endtask

    task automatic test_clear;
        // async reset with a stored result and a partial block
        for (int j = 0; j < 6; j++) step(1, 16'sd100, 0);
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 || fifo_level !== '0) begin
            n_err++;
            $display("FAIL clr_rst: v=%b d=%0d lvl=%0d want 0/0/0",
                     out_valid, out_data, fifo_level);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) step(1, 16'sd40, 0);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 16'sd40 ||
            fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL clr_rst40: v=%b d=%0d lvl=%0d want 1/40/1",
                     out_valid, out_data, fifo_level);
        end
        // sync clear with overflow set and a partial block
        for (int j = 0; j < 22; j++) step(1, 16'sd100, 0);
        sync_clr = 1'b1;
        step(1, 16'sd100, 1);
        sync_clr = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 ||
            fifo_level !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clr_sync: v=%b d=%0d lvl=%0d ovf=%b want 0/0/0/0",
                     out_valid, out_data, fifo_level, overflow);
        end
        for (int j = 0; j < 4; j++) step(1, 16'sd40, 0);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 16'sd40 ||
            fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL clr_sync40: v=%b d=%0d lvl=%0d want 1/40/1",
                     out_valid, out_data, fifo_level);
        end
        step(0, 0, 1);
    endtask

    task automatic test_random;
        int e_d;
        logic [LW-1:0] e_l;
        for (int c = 0; c < 800; c++) begin
            sync_clr = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 9) < 7, DW'($urandom),
                 $urandom_range(0, 9) < 3);
            e_d = (m_q.size() > 0) ? m_q[0] : 0;
            e_l = LW'(m_q.size());
            n_chk++;
            if (out_valid !== (m_q.size() > 0) || out_data !== DW'(e_d) ||
                fifo_level !== e_l || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rand@%0d: v=%b d=%0d lvl=%0d ovf=%b want %b/%0d/%0d/%b",
                         c, out_valid, out_data, fifo_level, overflow,
                         m_q.size() > 0, e_d, e_l, m_ovf);
            end
        end
        sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_average();
        test_extremes();
        test_overflow();
        test_full_pushpop();
        test_gaps();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
